// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared state encoding, block geometry and IV constants for the SHA-256 core
package sha256_pkg;

  localparam int SHA256_ROUNDS       = 64;
  localparam int SHA256_BLOCK_WORDS  = 16;
  localparam int SHA256_SCHED_DIRECT = 16;

  // H0 sits in the least significant slot: SHA256_IV[0] = H0 ... SHA256_IV[7] = H7.
  localparam logic [7:0][31:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HINIT,
    ST_LOAD,
    ST_INIT,
    ST_ROUND,
    ST_UPDATE,
    ST_DONE
  } sha256_state_e;

endpackage

// File: rtl/sha256_round_cnt.sv
// rtl/sha256_round_cnt.sv - wrap-at-max counter with synchronous clear and enable
module sha256_round_cnt #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // wrap flags the terminal count so the owner can step its FSM on the same edge
  assign wrap = (cnt_q == W'(MAX - 1));
  assign cnt  = cnt_q;

  // clear wins over enable; an enabled step at the terminal count returns to zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sha256_ctrl.sv
// rtl/sha256_ctrl.sv - SHA-256 block sequencer; optional abort input under SHA256_CTRL_ABORT_EN
module sha256_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int WORDS  = SHA256_BLOCK_WORDS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      word_valid,
  output logic                      word_ready,
  input  logic                      blk_last,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      wr_en,
  output logic [$clog2(WORDS)-1:0]  wr_idx,
  output logic                      h_init,
  output logic                      ld_work,
  output logic                      rnd_en,
  output logic [$clog2(ROUNDS)-1:0] rnd_idx,
  output logic                      sched_sel,
  output logic                      h_upd,
  output logic                      busy,
  output logic                      done
);

  localparam int RW = $clog2(ROUNDS);
  localparam logic [RW-1:0] SCHED_T = RW'(SHA256_SCHED_DIRECT);

  sha256_state_e state_q;
  sha256_state_e state_d;
  logic          last_q;
  logic          last_d;
  logic          abort_hit;
  logic          wr_wrap;
  logic          rnd_wrap;
  logic          rnd_clr;

`ifdef SHA256_CTRL_ABORT_EN
  assign abort_hit = abort && (state_q != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // every strobe is decoded from registered state; only wr_en looks at an input
  assign word_ready = (state_q == ST_LOAD);
  assign wr_en      = word_valid && word_ready;
  assign h_init     = (state_q == ST_HINIT);
  assign ld_work    = (state_q == ST_INIT);
  assign rnd_en     = (state_q == ST_ROUND);
  assign sched_sel  = rnd_en && (rnd_idx >= SCHED_T);
  assign h_upd      = (state_q == ST_UPDATE);
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign rnd_clr    = abort_hit || ld_work;

  sha256_round_cnt #(.MAX(WORDS)) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort_hit),
    .en   (wr_en),
    .cnt  (wr_idx),
    .wrap (wr_wrap)
  );

  sha256_round_cnt #(.MAX(ROUNDS)) u_rnd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (rnd_clr),
    .en   (rnd_en),
    .cnt  (rnd_idx),
    .wrap (rnd_wrap)
  );

  // next state: block load, init, rounds, update; chain to LOAD until the last block
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_HINIT;
      ST_HINIT:  state_d = ST_LOAD;
      ST_LOAD:   if (wr_en && wr_wrap) state_d = ST_INIT;
      ST_INIT:   state_d = ST_ROUND;
      ST_ROUND:  if (rnd_wrap) state_d = ST_UPDATE;
      ST_UPDATE: state_d = last_q ? ST_DONE : ST_LOAD;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  // final-block flag: captured only on the handshake of the block's last word
  always_comb begin
    last_d = last_q;
    if (wr_en && wr_wrap) last_d = blk_last;
    if (done || abort_hit) last_d = 1'b0;
  end

  // state and final-block registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_sha256_ctrl.sv
// tb/tb_sha256_ctrl.sv - scoreboard bench for sha256_ctrl; abort case under SHA256_CTRL_ABORT_EN
module tb_sha256_ctrl;

  localparam int EV_HINIT = 0;
  localparam int EV_WR    = 1;
  localparam int EV_INIT  = 2;
  localparam int EV_RND   = 3;
  localparam int EV_UPD   = 4;
  localparam int EV_DONE  = 5;

  typedef struct {
    int kind;
    int cyc;
    int idx;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       word_valid = 1'b0;
  logic       blk_last = 1'b0;
  logic       abort = 1'b0;
  logic       word_ready;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic       h_init;
  logic       ld_work;
  logic       rnd_en;
  logic [5:0] rnd_idx;
  logic       sched_sel;
  logic       h_upd;
  logic       busy;
  logic       done;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_cyc = -1;
  bit  mon_en = 1'b1;
  ev_t exp_q[$];
  int  m_kind;
  int  m_idx;
  int  m_n;
  ev_t m_e;
  int  c0;

  sha256_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .blk_last   (blk_last),
`ifdef SHA256_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .h_init     (h_init),
    .ld_work    (ld_work),
    .rnd_en     (rnd_en),
    .rnd_idx    (rnd_idx),
    .sched_sel  (sched_sel),
    .h_upd      (h_upd),
    .busy       (busy),
    .done       (done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // cycle number, referenced by stimulus and monitor
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: each strobe cycle pops one expected event and compares kind, cycle and index
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      m_kind = -1;
      m_idx  = 0;
      m_n    = 0;
      if (h_init)  begin m_kind = EV_HINIT; m_n++; end
      if (wr_en)   begin m_kind = EV_WR;    m_idx = int'(wr_idx); m_n++; end
      if (ld_work) begin m_kind = EV_INIT;  m_n++; end
      if (rnd_en)  begin m_kind = EV_RND;   m_idx = int'({sched_sel, rnd_idx}); m_n++; end
      if (h_upd)   begin m_kind = EV_UPD;   m_n++; end
      if (done)    begin m_kind = EV_DONE;  m_n++; done_cyc = cyc; end
      if (m_n > 1) begin
        checks++;
        errors++;
        $display("FAIL strobe_overlap cycle=%0d actual=%0d strobes required=1", cyc, m_n);
      end else if (m_kind >= 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cycle=%0d actual kind=%0d idx=%0d required none", cyc, m_kind, m_idx);
        end else begin
          m_e = exp_q.pop_front();
          if (m_e.kind != m_kind || m_e.cyc != cyc || m_e.idx != m_idx) begin
            errors++;
            $display("FAIL event actual kind=%0d cycle=%0d idx=%0d required kind=%0d cycle=%0d idx=%0d",
                     m_kind, cyc, m_idx, m_e.kind, m_e.cyc, m_e.idx);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input int idx);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // drives one message with valid held high (optionally stalled before word stall_w)
  // and pushes the strobe sequence the controller must produce
  task automatic run_msg(input int nblk, input int stall_w, input int stall_n,
                         input bit glitch, output int c_start);
    step();
    start      = 1'b1;
    word_valid = 1'b1;
    blk_last   = 1'b0;
    c_start    = cyc;
    step();
    start = 1'b0;
    push(EV_HINIT, cyc, 0);
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 16; w++) begin
        if (w == stall_w) begin
          for (int s = 0; s < stall_n; s++) begin
            step();
            word_valid = 1'b0;
            blk_last   = 1'b1;
            #1;
            check("stall_wr_en", int'(wr_en), 0);
            check("stall_wr_idx", int'(wr_idx), stall_w);
          end
        end
        step();
        word_valid = 1'b1;
        blk_last   = (w == 15) ? (b == nblk - 1) : (glitch && b == 0 && w == 3);
        push(EV_WR, cyc, w);
      end
      step();
      blk_last = 1'b0;
      push(EV_INIT, cyc, 0);
      for (int t = 0; t < 64; t++) begin
        step();
        start = glitch && (t == 10);
        push(EV_RND, cyc, ((t >= 16) ? 64 : 0) + t);
      end
      step();
      start = 1'b0;
      push(EV_UPD, cyc, 0);
    end
    step();
    word_valid = 1'b0;
    push(EV_DONE, cyc, 0);
    step();
    check("busy_after_done", int'(busy), 0);
    check("ready_after_done", int'(word_ready), 0);
  endtask

  task automatic drain(input string name);
    repeat (4) step();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    step();
    step();
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(word_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_wr_idx", int'(wr_idx), 0);
    check("rst_rnd_idx", int'(rnd_idx), 0);
    rst = 1'b0;
    word_valid = 1'b1;
    #1;
    check("idle_wr_en", int'(wr_en), 0);
    word_valid = 1'b0;

    // single block
    done_cyc = -1;
    run_msg(1, 99, 0, 1'b0, c0);
    drain("single_leftover");
    check("single_done_cycle", done_cyc - c0, 84);

    // two chained blocks
    done_cyc = -1;
    run_msg(2, 99, 0, 1'b0, c0);
    drain("two_blk_leftover");
    check("two_blk_done_cycle", done_cyc - c0, 166);

    // source stall of 5 cycles after word 7
    done_cyc = -1;
    run_msg(1, 8, 5, 1'b0, c0);
    drain("stall_leftover");
    check("stall_done_cycle", done_cyc - c0, 89);

    // start during ROUND and blk_last on word 3 are both ignored
    done_cyc = -1;
    run_msg(2, 99, 0, 1'b1, c0);
    drain("glitch_leftover");
    check("glitch_done_cycle", done_cyc - c0, 166);

    // reset in the middle of ROUND
    mon_en = 1'b0;
    step();
    start = 1'b1;
    word_valid = 1'b1;
    c0 = cyc;
    step();
    start = 1'b0;
    repeat (39) step();
    check("pre_rst_rnd_idx", int'(rnd_idx), 21);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rnd_en", int'(rnd_en), 0);
    check("mid_rst_rnd_idx", int'(rnd_idx), 0);
    check("mid_rst_wr_idx", int'(wr_idx), 0);
    check("mid_rst_ready", int'(word_ready), 0);
    step();
    rst = 1'b0;
    word_valid = 1'b0;
    step();
    mon_en = 1'b1;
    done_cyc = -1;
    run_msg(1, 99, 0, 1'b0, c0);
    drain("post_rst_leftover");
    check("post_rst_done_cycle", done_cyc - c0, 84);

`ifdef SHA256_CTRL_ABORT_EN
    // abort at round 30: nothing after that round may be issued
    step();
    start = 1'b1;
    word_valid = 1'b1;
    c0 = cyc;
    step();
    start = 1'b0;
    push(EV_HINIT, cyc, 0);
    for (int w = 0; w < 16; w++) begin
      step();
      blk_last = (w == 15);
      push(EV_WR, cyc, w);
    end
    step();
    blk_last = 1'b0;
    push(EV_INIT, cyc, 0);
    for (int t = 0; t <= 30; t++) begin
      step();
      push(EV_RND, cyc, ((t >= 16) ? 64 : 0) + t);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    word_valid = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rnd_idx", int'(rnd_idx), 0);
    check("abort_wr_idx", int'(wr_idx), 0);
    drain("abort_leftover");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
